register_port_arbiter: RTL and testbench

Shares the integer register file's single write port between the in-order pipeline writeback and the multi-cycle unit (divider/load return). Buffers multi-cycle results in a small FIFO and keeps a 32-bit busy scoreboard of registers with pending multi-cycle results. Drives read-after-write and write-after-write stalls to issue, and a hold request to the pipeline when buffered results are starved. Sits between writeback/multi-cycle unit and the register file write port.

---
 rtl/register_port_arbiter_pkg.sv | 47 ++++
 rtl/register_port_arbiter_result_fifo.sv | 50 +++++
 rtl/register_port_arbiter.sv | 138 +++++++++++++
 tb/tb_register_port_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/register_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
//   result_entry_t                 : buffered multi-cycle result {waddr, wdata}
//   register_write_in_type         : register-file write port bundle
//   register_port_arbiter_in_type  : all arbiter inputs, grouped
//   register_port_arbiter_out_type : all arbiter outputs, grouped
package register_port_arbiter_pkg;

  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;
  localparam int ENTRY_W = REG_AW + REG_DW;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [REG_DW-1:0] wdata;
  } result_entry_t;

  typedef struct packed {
    logic              wren;
    logic [REG_AW-1:0] waddr;
    logic [REG_DW-1:0] wdata;
  } register_write_in_type;

  typedef struct packed {
    register_write_in_type pipe;
    logic                  iss_valid;
    logic [REG_AW-1:0]     iss_waddr;
    logic [REG_AW-1:0]     chk_raddr1;
    logic [REG_AW-1:0]     chk_raddr2;
    logic [REG_AW-1:0]     chk_waddr;
    logic                  mcu_valid;
    result_entry_t         mcu;
  } register_port_arbiter_in_type;

  typedef struct packed {
    logic                  stall;
    logic                  mcu_ready;
    logic                  hold;
    register_write_in_type rf;
  } register_port_arbiter_out_type;

  // x0 is hardwired zero, so it never counts as busy.
  function automatic logic reg_busy(input logic [31:0] busy, input logic [REG_AW-1:0] a);
    return (a != '0) && busy[a];
  endfunction

endpackage

// File: rtl/register_port_arbiter_result_fifo.sv
// Small result FIFO for multi-cycle unit results.
//   i_clk, i_rst_n : clock, async active-low reset (drops all entries)
//   i_push/i_wdata : enqueue (ignored when full)
//   i_pop          : dequeue head (ignored when empty)
//   o_full/o_empty : status; o_head : current head entry
module register_port_arbiter_result_fifo
  import register_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [ENTRY_W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0]        r_wptr, r_rptr;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               w_push, w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Power-of-two depth: natural pointer overflow is the modulo wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is only meaningful between pointers, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/register_port_arbiter.sv
// Shares the integer register file's single write port between pipeline
// writeback (always wins) and buffered multi-cycle results. Tracks busy
// registers with pending multi-cycle results, stalls dependent issue, and
// requests a pipeline hold when buffered results starve.
//   i_clk, i_rst_n                        : clock, async active-low reset
//   i_pipe_wren/_waddr/_wdata             : pipeline writeback (no back-pressure)
//   i_iss_valid/_waddr                    : multi-cycle op issued to rd
//   i_chk_raddr1/_raddr2/_waddr, o_stall  : hazard check for instruction in issue
//   i_mcu_valid/_waddr/_wdata, o_mcu_ready: multi-cycle result handshake
//   o_hold                                : registered pipeline freeze request
//   o_rf_wren/_waddr/_wdata               : register-file write port
module register_port_arbiter
  import register_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_wren,
  input  logic [4:0]  i_pipe_waddr,
  input  logic [31:0] i_pipe_wdata,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_waddr,
  input  logic [4:0]  i_chk_raddr1,
  input  logic [4:0]  i_chk_raddr2,
  input  logic [4:0]  i_chk_waddr,
  output logic        o_stall,
  input  logic        i_mcu_valid,
  input  logic [4:0]  i_mcu_waddr,
  input  logic [31:0] i_mcu_wdata,
  output logic        o_mcu_ready,
  output logic        o_hold,
  output logic        o_rf_wren,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  register_port_arbiter_in_type  w_in;
  register_port_arbiter_out_type w_out;

  logic               w_full, w_empty, w_push, w_pop;
  logic [ENTRY_W-1:0] w_head_bits;
  result_entry_t      w_head;
  logic [31:0]        r_busy, w_busy_set, w_busy_clr, w_busy_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_hold;

  always_comb begin
    w_in            = '0;
    w_in.pipe.wren  = i_pipe_wren;
    w_in.pipe.waddr = i_pipe_waddr;
    w_in.pipe.wdata = i_pipe_wdata;
    w_in.iss_valid  = i_iss_valid;
    w_in.iss_waddr  = i_iss_waddr;
    w_in.chk_raddr1 = i_chk_raddr1;
    w_in.chk_raddr2 = i_chk_raddr2;
    w_in.chk_waddr  = i_chk_waddr;
    w_in.mcu_valid  = i_mcu_valid;
    w_in.mcu.waddr  = i_mcu_waddr;
    w_in.mcu.wdata  = i_mcu_wdata;
  end

  // Results to x0 are handshaken but dropped: nothing to write, nothing busy.
  assign w_push = w_in.mcu_valid && !w_full && (w_in.mcu.waddr != '0);
  // Drain only on cycles the pipeline leaves the port free.
  assign w_pop  = !w_in.pipe.wren && !w_empty;
  assign w_head = result_entry_t'(w_head_bits);

  register_port_arbiter_result_fifo #(.DEPTH(DEPTH)) u_result_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_in.mcu),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head_bits)
  );

  // Busy scoreboard: set applied after clear so a re-issue to the register
  // being drained keeps it busy for the newer result.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (w_pop) w_busy_clr[w_head.waddr] = 1'b1;
    if (w_in.iss_valid && (w_in.iss_waddr != '0)) w_busy_set[w_in.iss_waddr] = 1'b1;
    w_busy_next = (r_busy & ~w_busy_clr) | w_busy_set;
  end

  // Starvation: count cycles a waiting result loses the port to the pipe.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_pop)
      w_cnt_next = '0;
    else if (!w_empty && w_in.pipe.wren && (r_cnt < STARVE_LIM))
      w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_hold <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_cnt  <= w_cnt_next;
      // A pop zeroes the counter, so this also drops hold the cycle after a pop.
      r_hold <= (w_cnt_next == STARVE_LIM);
    end
  end

  always_comb begin
    w_out           = '0;
    w_out.stall     = reg_busy(r_busy, w_in.chk_raddr1) |
                      reg_busy(r_busy, w_in.chk_raddr2) |
                      reg_busy(r_busy, w_in.chk_waddr);
    w_out.mcu_ready = !w_full;
    w_out.hold      = r_hold;
    if (w_in.pipe.wren) begin
      w_out.rf = w_in.pipe;
    end else if (!w_empty) begin
      w_out.rf.wren  = 1'b1;
      w_out.rf.waddr = w_head.waddr;
      w_out.rf.wdata = w_head.wdata;
    end
  end

  assign o_stall     = w_out.stall;
  assign o_mcu_ready = w_out.mcu_ready;
  assign o_hold      = w_out.hold;
  assign o_rf_wren   = w_out.rf.wren;
  assign o_rf_waddr  = w_out.rf.waddr;
  assign o_rf_wdata  = w_out.rf.wdata;

endmodule

// File: tb/tb_register_port_arbiter.sv
module tb_register_port_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wren = 0, iss_valid = 0, mcu_valid = 0;
  logic [4:0]  pipe_waddr = 0, iss_waddr = 0, chk1 = 0, chk2 = 0, chkw = 0, mcu_waddr = 0;
  logic [31:0] pipe_wdata = 0, mcu_wdata = 0;
  logic        stall, mcu_ready, hold, rf_wren;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  register_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pipe_wren(pipe_wren), .i_pipe_waddr(pipe_waddr), .i_pipe_wdata(pipe_wdata),
    .i_iss_valid(iss_valid), .i_iss_waddr(iss_waddr),
    .i_chk_raddr1(chk1), .i_chk_raddr2(chk2), .i_chk_waddr(chkw),
    .o_stall(stall),
    .i_mcu_valid(mcu_valid), .i_mcu_waddr(mcu_waddr), .i_mcu_wdata(mcu_wdata),
    .o_mcu_ready(mcu_ready), .o_hold(hold),
    .o_rf_wren(rf_wren), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata)
  );

  typedef struct {
    logic pw; logic [4:0] pa; logic [31:0] pd;
    logic iv; logic [4:0] ia; logic [4:0] c1;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic ew; logic [4:0] ea; logic [31:0] ed;
    logic er, es, eh;
  } vec_t;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pw, logic [4:0] pa, logic [31:0] pd,
                              logic iv, logic [4:0] ia, logic [4:0] c1,
                              logic mv, logic [4:0] ma, logic [31:0] md,
                              logic ew, logic [4:0] ea, logic [31:0] ed,
                              logic er, logic es, logic eh);
    vec_t v;
    v.pw = pw; v.pa = pa; v.pd = pd; v.iv = iv; v.ia = ia; v.c1 = c1;
    v.mv = mv; v.ma = ma; v.md = md; v.ew = ew; v.ea = ea; v.ed = ed;
    v.er = er; v.es = es; v.eh = eh;
    return v;
  endfunction

  // Output vector layout: {rf_wren, rf_waddr, rf_wdata, mcu_ready, stall, hold}
  task automatic check(input string name, input logic [40:0] exp);
    logic [40:0] act;
    act = {rf_wren, rf_waddr, rf_wdata, mcu_ready, stall, hold};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got wren=%0b waddr=%0d wdata=%h ready=%0b stall=%0b hold=%0b, want wren=%0b waddr=%0d wdata=%h ready=%0b stall=%0b hold=%0b",
                  name, act[40], act[39:35], act[34:3], act[2], act[1], act[0],
                  exp[40], exp[39:35], exp[34:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic iv, input logic [4:0] ia,
                       input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cw,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    pipe_wren = pw; pipe_waddr = pa; pipe_wdata = pd;
    iss_valid = iv; iss_waddr = ia; chk1 = c1; chk2 = c2; chkw = cw;
    mcu_valid = mv; mcu_waddr = ma; mcu_wdata = md;
  endtask

  // Reference model state
  ent_t    mq[$];
  bit [31:0] mbusy;
  int      mcnt;
  bit      mhold;

  initial begin
    // ---------------- reset / idle ----------------
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    #2 check("reset_idle", {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});

    // ---------------- directed table ----------------
    tbl.push_back(mk(0,0,0, 1,5,0, 0,0,0,        0,0,0,        1,0,0)); // issue div x5
    tbl.push_back(mk(0,0,0, 0,0,5, 0,0,0,        0,0,0,        1,1,0));
    tbl.push_back(mk(0,0,0, 0,0,5, 0,0,0,        0,0,0,        1,1,0));
    tbl.push_back(mk(0,0,0, 0,0,5, 0,0,0,        0,0,0,        1,1,0));
    tbl.push_back(mk(0,0,0, 0,0,5, 1,5,32'h2A,   0,0,0,        1,1,0)); // result arrives
    tbl.push_back(mk(0,0,0, 0,0,5, 0,0,0,        1,5,32'h2A,   1,1,0)); // drained
    tbl.push_back(mk(0,0,0, 0,0,5, 0,0,0,        0,0,0,        1,0,0)); // stall gone
    tbl.push_back(mk(1,3,32'h11, 0,0,0, 1,7,32'h22, 1,3,32'h11, 1,0,0));
    tbl.push_back(mk(1,3,32'h11, 0,0,0, 1,8,32'h33, 1,3,32'h11, 1,0,0));
    tbl.push_back(mk(1,3,32'h11, 0,0,0, 0,0,0,      1,3,32'h11, 0,0,0)); // full
    tbl.push_back(mk(1,3,32'h11, 0,0,0, 0,0,0,      1,3,32'h11, 0,0,0));
    tbl.push_back(mk(1,3,32'h11, 0,0,0, 0,0,0,      1,3,32'h11, 0,0,1)); // hold up
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,        1,7,32'h22,   0,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,        1,8,32'h33,   1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,        0,0,0,        1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,0,32'hFFFF_FFFF, 0,0,0,   1,0,0)); // x0 result
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,        0,0,0,        1,0,0));
    tbl.push_back(mk(0,0,0, 1,9,0, 0,0,0,        0,0,0,        1,0,0)); // issue x9
    tbl.push_back(mk(0,0,0, 0,0,9, 1,9,32'hAB,   0,0,0,        1,1,0));
    tbl.push_back(mk(0,0,0, 1,9,9, 0,0,0,        1,9,32'hAB,   1,1,0)); // pop + reissue
    tbl.push_back(mk(0,0,0, 0,0,9, 0,0,0,        0,0,0,        1,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,10,32'h100, 0,0,0,        1,0,0));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(0,0,0, 0,0,0, 1,5'(10+k),32'h100+k, 1,5'(9+k),32'h100+k-1, 1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,        1,15,32'h105, 1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,        0,0,0,        1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].iv, tbl[i].ia,
            tbl[i].c1, 5'd0, 5'd0, tbl[i].mv, tbl[i].ma, tbl[i].md);
      #2 check($sformatf("vec%0d", i),
               {tbl[i].ew, tbl[i].ea, tbl[i].ed, tbl[i].er, tbl[i].es, tbl[i].eh});
    end

    // ---------------- async reset with 2 entries queued ----------------
    @(negedge clk); drive(1,1,32'h1, 1,20, 0,0,0, 1,20,32'hA1);
    @(negedge clk); drive(1,1,32'h1, 0,0,  0,0,0, 1,21,32'hA2);
    @(negedge clk); drive(0,0,0,     0,0, 20,0,0, 0,0,0);
    #1 check("pre_reset_queued", {1'b1, 5'd20, 32'hA1, 1'b0, 1'b1, 1'b0});
    #1 rst_n = 1'b0;
    #1 check("async_reset_flush", {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2 check("post_reset_empty", {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});

    // ---------------- randomized against reference model ----------------
    mq.delete(); mbusy = '0; mcnt = 0; mhold = 0;
    for (int n = 0; n < 400; n++) begin
      logic pw, iv, mv;
      logic [4:0] pa, ia, c1, c2, cw, ma;
      logic [31:0] pd, md;
      logic ew; logic [4:0] ea; logic [31:0] ed;
      logic er, es;
      bit pop, push;
      int sz;
      ent_t e;
      pw = ($urandom_range(0, 99) < 45); pa = 5'($urandom_range(0, 7)); pd = $urandom;
      iv = ($urandom_range(0, 99) < 30); ia = 5'($urandom_range(0, 7));
      c1 = 5'($urandom_range(0, 7)); c2 = 5'($urandom_range(0, 7)); cw = 5'($urandom_range(0, 7));
      mv = ($urandom_range(0, 99) < 50); ma = 5'($urandom_range(0, 7)); md = $urandom;
      @(negedge clk);
      drive(pw, pa, pd, iv, ia, c1, c2, cw, mv, ma, md);
      sz = mq.size();
      ew = 0; ea = 0; ed = 0;
      if (pw) begin ew = 1; ea = pa; ed = pd; end
      else if (sz > 0) begin ew = 1; ea = mq[0].a; ed = mq[0].d; end
      er = (sz < DEPTH);
      es = (c1 != 0 && mbusy[c1]) || (c2 != 0 && mbusy[c2]) || (cw != 0 && mbusy[cw]);
      #2 check($sformatf("rand%0d", n), {ew, ea, ed, er, es, mhold});
      pop  = !pw && sz > 0;
      push = mv && sz < DEPTH && ma != 0;
      if (pop) begin e = mq.pop_front(); mbusy[e.a] = 1'b0; end
      if (iv && ia != 0) mbusy[ia] = 1'b1;
      if (push) begin e.a = ma; e.d = md; mq.push_back(e); end
      if (pop) begin mcnt = 0; mhold = 0; end
      else begin
        if (sz > 0 && pw && mcnt < SMAX) mcnt++;
        if (mcnt == SMAX) mhold = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
